mult_result_stage: RTL and testbench

MULT_RESULT_STAGE -- requirements
Module: mult_result_stage

---
 rtl/mult_pkg.sv | 20 ++
 rtl/skid_buffer.sv | 73 +++++++
 rtl/mult_result_stage.sv | 70 +++++++
 tb/tb_mult_result_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the multiplier result stage
package mult_pkg;

  localparam int unsigned MULT_SIZE = 8;
  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic [MULT_SIZE-1:0] result;
    logic [MULT_SIZE-1:0] high;
    logic                 ovf;
  } entry_t;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry FIFO with registered-state ready/valid decode
module skid_buffer
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             push_ready_o,
  output logic             pop_valid_o,
  output logic [WIDTH-1:0] pop_data_o,
  input  logic             pop_ready_i
);

  fifo_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  // Both handshakes decode only the state register, so ready never sees pop_ready_i.
  assign push_ready_o = (state_q != ST_TWO);
  assign pop_valid_o  = (state_q != ST_EMPTY);
  assign pop_data_o   = head_q;

  assign push = push_valid_i && push_ready_o;
  assign pop  = pop_valid_o && pop_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = push_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = push_data_i;
        end else if (push) begin
          tail_d  = push_data_i;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/mult_result_stage.sv
// rtl/mult_result_stage.sv - formats multiplier products, queues them and counts overflows
module mult_result_stage
  import mult_pkg::*;
#(
  parameter int SIZE = MULT_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*SIZE-1:0] in_product,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sat_en,
  output logic [SIZE-1:0]   out_result,
  output logic [SIZE-1:0]   out_high,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  ovf_count,
  input  logic              cnt_clr
);

  entry_t            push_entry;
  entry_t            head_entry;
  logic              push;
  logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;

  always_comb begin
    push_entry.high   = in_product[2*SIZE-1:SIZE];
    push_entry.ovf    = |in_product[2*SIZE-1:SIZE];
    push_entry.result = (push_entry.ovf && sat_en) ? '1 : in_product[SIZE-1:0];
  end

  skid_buffer #(
    .WIDTH($bits(entry_t))
  ) u_skid_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (in_valid),
    .push_data_i  (push_entry),
    .push_ready_o (in_ready),
    .pop_valid_o  (out_valid),
    .pop_data_o   (head_entry),
    .pop_ready_i  (out_ready)
  );

  assign push       = in_valid && in_ready;
  assign out_result = head_entry.result;
  assign out_high   = head_entry.high;
  assign out_ovf    = head_entry.ovf;
  assign ovf_count  = ovf_count_q;

  // Clear wins over a same-cycle overflowed push; the count sticks at its maximum.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (cnt_clr) begin
      ovf_count_d = '0;
    end else if (push && push_entry.ovf && (ovf_count_q != CNT_MAX)) begin
      ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

endmodule

// File: tb/tb_mult_result_stage.sv
// tb/tb_mult_result_stage.sv - directed self-checking bench for mult_result_stage
module tb_mult_result_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_product;
  logic        in_valid;
  logic        in_ready;
  logic        sat_en;
  logic [7:0]  out_result;
  logic [7:0]  out_high;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  ovf_count;
  logic        cnt_clr;

  int vec_cnt;
  int err_cnt;

  mult_result_stage #(.SIZE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_product (in_product),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sat_en     (sat_en),
    .out_result (out_result),
    .out_high   (out_high),
    .out_ovf    (out_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf_count  (ovf_count),
    .cnt_clr    (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_product = 16'h0; sat_en = 1'b0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    vec_cnt++; if (ovf_count !== 8'd0) begin err_cnt++; $display("FAIL reset_ovf_count got %0d want 0", ovf_count); end
    vec_cnt++; if ({out_result, out_high, out_ovf} !== 17'h0) begin
      err_cnt++; $display("FAIL reset_fields got %h/%h/%b want 00/00/0", out_result, out_high, out_ovf);
    end
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1; in_valid = 1'b1; in_product = 16'h0042; sat_en = 1'b0;
    tick();
    in_valid = 1'b0; in_product = 16'hFFFF; sat_en = 1'b1;
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL pass_valid got %0b want 1", out_valid); end
    vec_cnt++; if (out_result !== 8'h42) begin err_cnt++; $display("FAIL pass_result got %h want 42", out_result); end
    vec_cnt++; if (out_high !== 8'h00) begin err_cnt++; $display("FAIL pass_high got %h want 00", out_high); end
    vec_cnt++; if (out_ovf !== 1'b0) begin err_cnt++; $display("FAIL pass_ovf got %b want 0", out_ovf); end
    vec_cnt++; if (ovf_count !== 8'd0) begin err_cnt++; $display("FAIL pass_count got %0d want 0", ovf_count); end
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL pass_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_sat_trunc();
    out_ready = 1'b0; in_valid = 1'b1; in_product = 16'h1234; sat_en = 1'b1;
    tick();
    vec_cnt++; if (out_result !== 8'hFF) begin err_cnt++; $display("FAIL sat_result got %h want ff", out_result); end
    vec_cnt++; if (out_high !== 8'h12) begin err_cnt++; $display("FAIL sat_high got %h want 12", out_high); end
    vec_cnt++; if (out_ovf !== 1'b1) begin err_cnt++; $display("FAIL sat_ovf got %b want 1", out_ovf); end
    out_ready = 1'b1; sat_en = 1'b0;
    tick();
    in_valid = 1'b0;
    vec_cnt++; if (out_result !== 8'h34) begin err_cnt++; $display("FAIL trunc_result got %h want 34", out_result); end
    vec_cnt++; if (out_high !== 8'h12) begin err_cnt++; $display("FAIL trunc_high got %h want 12", out_high); end
    vec_cnt++; if (ovf_count !== 8'd2) begin err_cnt++; $display("FAIL trunc_count got %0d want 2", ovf_count); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[3];
    int idx;
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03;
    out_ready = 1'b0; sat_en = 1'b0;
    in_valid = 1'b1; in_product = 16'h0001; tick();
    in_product = 16'h0002; tick();
    in_product = 16'h0003;
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
    tick();
    vec_cnt++; if (out_result !== 8'h01) begin err_cnt++; $display("FAIL bp_stall_head got %h want 01", out_result); end
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      if (out_valid && out_ready) begin
        vec_cnt++;
        if (out_result !== exp_q[idx]) begin
          err_cnt++; $display("FAIL bp_order[%0d] got %h want %h", idx, out_result, exp_q[idx]);
        end
        idx++;
      end
      if (in_valid && in_ready) begin
        @(posedge clk); #1; in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    vec_cnt++; if (idx !== 3) begin err_cnt++; $display("FAIL bp_pop_count got %0d want 3", idx); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_duplicate got %0b want 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; sat_en = 1'b0; in_valid = 1'b1;
    for (int i = 8'h10; i <= 8'h17; i++) begin
      in_product = 16'(i);
      tick();
      vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL stream_valid[%0h] got %0b want 1", i, out_valid); end
      vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL stream_ready[%0h] got %0b want 1", i, in_ready); end
      vec_cnt++; if (out_result !== 8'(i)) begin err_cnt++; $display("FAIL stream_data got %h want %h", out_result, 8'(i)); end
    end
    in_valid = 1'b0;
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_counter();
    out_ready = 1'b1; sat_en = 1'b0; in_valid = 1'b1; in_product = 16'h0100;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    vec_cnt++; if (ovf_count !== 8'd0) begin err_cnt++; $display("FAIL cnt_preclear got %0d want 0", ovf_count); end
    for (int i = 0; i < 300; i++) tick();
    vec_cnt++; if (ovf_count !== 8'd255) begin err_cnt++; $display("FAIL cnt_saturate got %0d want 255", ovf_count); end
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    vec_cnt++; if (ovf_count !== 8'd0) begin err_cnt++; $display("FAIL cnt_clr_priority got %0d want 0", ovf_count); end
    tick();
    vec_cnt++; if (ovf_count !== 8'd1) begin err_cnt++; $display("FAIL cnt_after_clr got %0d want 1", ovf_count); end
    in_valid = 1'b0; in_product = 16'hABCD;
    tick(); tick();
    vec_cnt++; if (ovf_count !== 8'd1) begin err_cnt++; $display("FAIL cnt_idle_hold got %0d want 1", ovf_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
    in_product = 16'h0305; tick();
    in_product = 16'h0306; tick();
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rstmid_full got %0b want 0", in_ready); end
    rst_n = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; in_product = 16'h0999;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_ready got %0b want 1", in_ready); end
    vec_cnt++; if (ovf_count !== 8'd0) begin err_cnt++; $display("FAIL rstmid_count got %0d want 0", ovf_count); end
    out_ready = 1'b1;
    tick(); tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_stale got %0b want 0", out_valid); end
    in_valid = 1'b1; in_product = 16'h0007; tick(); in_valid = 1'b0;
    vec_cnt++; if (out_result !== 8'h07) begin err_cnt++; $display("FAIL rstmid_fresh got %h want 07", out_result); end
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_end got %0b want 0", out_valid); end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_passthrough();
    test_sat_trunc();
    test_backpressure();
    test_stream();
    test_counter();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
